// File: rtl/uart_mul_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | uart_mul_pkg                                                       |
// | Shared state encoding and width helpers for the UART multiply      |
// | bridge.                                                            |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
package uart_mul_pkg;

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    MUL     = 2'd1,
    SEND    = 2'd2,
    WAIT_TX = 2'd3
  } state_t;

  function automatic int calc_res_w(input int op_w, input int coef_w);
    return op_w + coef_w;
  endfunction

  function automatic int calc_res_bytes(input int res_w);
    return (res_w + 7) / 8;
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_mul_bridge_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | uart_mul_bridge_if                                                 |
// | Byte receive / byte transmit handshake between the UART and the    |
// | multiply bridge.                                                   |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
interface uart_mul_bridge_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       tx_busy;
  logic       tx_done;
  logic [7:0] tx_data;
  logic       tx_start;

  // UART side: delivers received bytes and reports transmitter status.
  modport master (
    output rx_data, rx_valid, tx_busy, tx_done,
    input  tx_data, tx_start
  );

  // Bridge side.
  modport slave (
    input  rx_data, rx_valid, tx_busy, tx_done,
    output tx_data, tx_start
  );
endinterface
`default_nettype wire

// File: rtl/shift_add_mul.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | shift_add_mul                                                      |
// | Sequential shift-add multiplier, one operand bit per cycle, LSB    |
// | first; OP_W cycles per product.                                    |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module shift_add_mul
  import uart_mul_pkg::*;
#(
  parameter int OP_W   = 8,
  parameter int COEF_W = 8
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  start_i,
  input  logic [OP_W-1:0]                       operand_i,
  input  logic [COEF_W-1:0]                     coef_i,
  output logic                                  done_o,
  output logic [calc_res_w(OP_W, COEF_W)-1:0]   product_o
);

  localparam int RES_W = calc_res_w(OP_W, COEF_W);
  localparam int CNT_W = $clog2(OP_W + 1);

  logic [OP_W-1:0]  a_q;
  logic [RES_W-1:0] b_q;
  logic [RES_W-1:0] acc_q;
  logic [CNT_W-1:0] cnt_q;
  logic             busy_q;
  logic [RES_W-1:0] sum_d;

  assign sum_d = acc_q + (a_q[0] ? b_q : '0);

  // done_o marks the final step; product_o already carries that step's sum.
  assign done_o    = busy_q && (cnt_q == CNT_W'(1));
  assign product_o = sum_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q    <= '0;
      b_q    <= '0;
      acc_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else if (start_i) begin
      a_q    <= operand_i;
      b_q    <= RES_W'(coef_i);
      acc_q  <= '0;
      cnt_q  <= CNT_W'(OP_W);
      busy_q <= 1'b1;
    end else if (busy_q) begin
      acc_q <= sum_d;
      a_q   <= a_q >> 1;
      b_q   <= b_q << 1;
      cnt_q <= cnt_q - CNT_W'(1);
      if (cnt_q == CNT_W'(1)) begin
        busy_q <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/uart_mul_bridge.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | uart_mul_bridge                                                    |
// | Collects OP_BYTES rx bytes into an operand, multiplies by coef and |
// | returns the result MSB byte first. Optional macro ACCUM_EN sends a |
// | running wrap-around sum of products instead of each product.       |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module uart_mul_bridge
  import uart_mul_pkg::*;
#(
  parameter int OP_BYTES    = 1,
  parameter int COEF_W      = 8,
  parameter int TIMEOUT_CYC = 1000000
) (
  input  logic              clk_fpga,
  input  logic              reset,
  input  logic [COEF_W-1:0] coef,
  input  logic              acc_clr,
  uart_mul_bridge_if.slave  uart,
  output logic              busy,
  output logic              overrun,
  output logic              overrun_st
);

  localparam int OP_W  = 8 * OP_BYTES;
  localparam int RES_W = calc_res_w(OP_W, COEF_W);
`ifdef ACCUM_EN
  localparam int ACC_W = RES_W + 8;
  localparam int OUT_BYTES = calc_res_bytes(ACC_W);
`else
  localparam int OUT_BYTES = calc_res_bytes(RES_W);
`endif
  localparam int OUT_W = 8 * OUT_BYTES;
  localparam int CNT_W = $clog2(OP_BYTES + 1);
  localparam int TO_W  = $clog2(TIMEOUT_CYC + 1);
  localparam int BL_W  = $clog2(OUT_BYTES + 1);

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [OP_W-1:0]  op_q;
  logic [TO_W-1:0]  to_q;
  logic [OUT_W-1:0] out_q;
  logic [BL_W-1:0]  left_q;
  logic [7:0]       tx_data_q;
  logic             tx_start_q;
  logic             busy_q;
  logic             overrun_q;
  logic             overrun_st_q;

  logic [OP_W-1:0]  op_d;
  logic             last_byte_d;
  logic             mul_done;
  logic [RES_W-1:0] product;
  logic [OUT_W-1:0] result_d;

  assign op_d        = OP_W'({op_q, uart.rx_data});
  assign last_byte_d = (state_q == COLLECT) && uart.rx_valid &&
                       (cnt_q == CNT_W'(OP_BYTES - 1));

  // The multiplier is loaded on the same edge that enters MUL, so the
  // completing byte and coef are captured together.
  shift_add_mul #(
    .OP_W   (OP_W),
    .COEF_W (COEF_W)
  ) u_mul (
    .clk       (clk_fpga),
    .rst_n     (reset),
    .start_i   (last_byte_d),
    .operand_i (op_d),
    .coef_i    (coef),
    .done_o    (mul_done),
    .product_o (product)
  );

`ifdef ACCUM_EN
  logic [ACC_W-1:0] acc_q;
  logic [ACC_W-1:0] acc_d;

  assign acc_d    = acc_q + ACC_W'(product);
  assign result_d = OUT_W'(acc_d);

  always_ff @(posedge clk_fpga or negedge reset) begin
    if (!reset) begin
      acc_q <= '0;
    end else if ((state_q == COLLECT) && acc_clr) begin
      acc_q <= '0;
    end else if ((state_q == MUL) && mul_done) begin
      acc_q <= acc_d;
    end
  end
`else
  logic unused_acc_clr;

  assign unused_acc_clr = acc_clr;
  assign result_d       = OUT_W'(product);
`endif

  always_ff @(posedge clk_fpga or negedge reset) begin
    if (!reset) begin
      state_q      <= COLLECT;
      cnt_q        <= '0;
      op_q         <= '0;
      to_q         <= '0;
      out_q        <= '0;
      left_q       <= '0;
      tx_data_q    <= '0;
      tx_start_q   <= 1'b0;
      busy_q       <= 1'b0;
      overrun_q    <= 1'b0;
      overrun_st_q <= 1'b0;
    end else begin
      tx_start_q <= 1'b0;
      overrun_q  <= 1'b0;
      if (uart.rx_valid && (state_q != COLLECT)) begin
        overrun_q    <= 1'b1;
        overrun_st_q <= 1'b1;
      end

      case (state_q)
        COLLECT: begin
          if (uart.rx_valid) begin
            to_q <= '0;
            if (last_byte_d) begin
              cnt_q   <= '0;
              op_q    <= '0;
              busy_q  <= 1'b1;
              state_q <= MUL;
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
              op_q  <= op_d;
            end
          end else if (cnt_q != '0) begin
            // Partial operand abandoned after TIMEOUT_CYC idle cycles.
            if (to_q == TO_W'(TIMEOUT_CYC - 1)) begin
              to_q  <= '0;
              cnt_q <= '0;
              op_q  <= '0;
            end else begin
              to_q <= to_q + TO_W'(1);
            end
          end
        end

        MUL: begin
          if (mul_done) begin
            out_q   <= result_d;
            left_q  <= BL_W'(OUT_BYTES);
            state_q <= SEND;
          end
        end

        SEND: begin
          if (!uart.tx_busy) begin
            tx_data_q  <= out_q[OUT_W-1 -: 8];
            tx_start_q <= 1'b1;
            out_q      <= out_q << 8;
            left_q     <= left_q - BL_W'(1);
            state_q    <= WAIT_TX;
          end
        end

        WAIT_TX: begin
          if (uart.tx_done) begin
            if (left_q != '0) begin
              state_q <= SEND;
            end else begin
              busy_q  <= 1'b0;
              state_q <= COLLECT;
            end
          end
        end

        default: begin
          state_q <= COLLECT;
        end
      endcase
    end
  end

  assign uart.tx_data  = tx_data_q;
  assign uart.tx_start = tx_start_q;
  assign busy          = busy_q;
  assign overrun       = overrun_q;
  assign overrun_st    = overrun_st_q;

endmodule
`default_nettype wire
